// File: rtl/cu_pkg.sv
// Shared types and constants for the control sequencer and its watchdog.
package cu_pkg;

    // Instruction-cycle states of the sequencer
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd5
    } cu_state_e;

    // Fault codes reported on fault_code
    localparam logic [1:0] FLT_NONE   = 2'b00;
    localparam logic [1:0] FLT_FETCH  = 2'b01;
    localparam logic [1:0] FLT_EXEC   = 2'b10;
    localparam logic [1:0] FLT_EU_IDX = 2'b11;

    // Bit positions inside the flag register
    localparam int FLG_C = 1;
    localparam int FLG_Z = 0;

endpackage

// File: rtl/cu_wdog.sv
// Handshake watchdog: counts waiting cycles and flags the cycle on which the
// count would reach TIMEOUT, so the caller can leave on that same edge.
module cu_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins over increment, otherwise hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Expiry is independent of clr so the FSM can use it to pick its next state
    always_comb begin
        expired = 1'b0;
        if (en && (cnt_q == LIMIT)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Control sequencer: drives fetch -> decode -> execute -> update over cs/ready
// handshakes, owns pc/ir/flags, and latches a sticky fault on timeout or a bad
// execution-unit index. All cs outputs come straight from flops.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int IR_W     = 32,
    parameter int ADDR_W   = 16,
    parameter int N_EU     = 2,
    parameter int EU_SEL_W = 3,
    parameter int PC_STEP  = 2,
    parameter int PC_RESET = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    output logic                cs_fcu,
    output logic [ADDR_W-1:0]   fetch_address,
    input  logic                ready_fcu,
    input  logic [IR_W-1:0]     ir_in,
    output logic [IR_W-1:0]     ir,
    output logic                cs_dec,
    input  logic                ready_dec,
    input  logic [EU_SEL_W-1:0] eu_idx,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [N_EU-1:0]     cs_eu,
    input  logic [N_EU-1:0]     ready_eu,
    input  logic                cout_in,
    input  logic                zero_in,
    output logic [1:0]          flag,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam logic [ADDR_W-1:0]   PC_RST_V  = ADDR_W'(PC_RESET);
    localparam logic [ADDR_W-1:0]   PC_STEP_V = ADDR_W'(PC_STEP);
    localparam logic [EU_SEL_W:0]   N_EU_V    = (EU_SEL_W + 1)'(N_EU);

    cu_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [IR_W-1:0]       ir_q, ir_d;
    logic [1:0]            flag_q, flag_d;
    logic [EU_SEL_W-1:0]   eu_idx_q, eu_idx_d;
    logic                  br_taken_q, br_taken_d;
    logic [ADDR_W-1:0]     br_target_q, br_target_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fault_code_q, fault_code_d;
    logic                  cs_fcu_q, cs_fcu_d;
    logic                  cs_dec_q, cs_dec_d;
    logic [N_EU-1:0]       cs_eu_q, cs_eu_d;
    logic                  busy_q, busy_d;

    logic                  sel_ready_s;
    logic                  wd_en_s;
    logic                  wd_clr_s;
    logic                  wd_expired_s;
    logic                  eu_bad_s;

    // Ready of the selected unit only; other units' ready lines are ignored
    always_comb begin
        sel_ready_s = 1'b0;
        for (int i = 0; i < N_EU; i++) begin
            if (eu_idx_q == EU_SEL_W'(i)) begin
                sel_ready_s = sel_ready_s | ready_eu[i];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // Watchdog runs only while a handshake is outstanding
    always_comb begin
        wd_en_s  = 1'b0;
        eu_bad_s = ({1'b0, eu_idx} >= N_EU_V);
        case (state_q)
            ST_FETCH:  wd_en_s = ~ready_fcu;
            ST_DECODE: wd_en_s = ~ready_dec;
            ST_EXEC:   wd_en_s = ~sel_ready_s;
            default:   wd_en_s = 1'b0;
        endcase
    end

    // Any state change restarts the wait budget
    always_comb begin
        wd_clr_s = 1'b0;
        if (state_d != state_q) begin
            wd_clr_s = 1'b1;
        end else begin
            wd_clr_s = 1'b0;
        end
    end

    cu_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Next-state, datapath updates, and registered cs/status derived from state_d
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        flag_d       = flag_q;
        eu_idx_d     = eu_idx_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        cs_eu_d      = {N_EU{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = PC_RST_V;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (ready_fcu) begin
                    ir_d    = ir_in;
                    state_d = ST_DECODE;
                end else if (wd_expired_s) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FLT_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (ready_dec) begin
                    if (eu_bad_s) begin
                        state_d      = ST_FAULT;
                        fault_d      = 1'b1;
                        fault_code_d = FLT_EU_IDX;
                    end else begin
                        eu_idx_d    = eu_idx;
                        br_taken_d  = branch_taken;
                        br_target_d = branch_target;
                        state_d     = ST_EXEC;
                    end
                end else if (wd_expired_s) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FLT_EXEC;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_EXEC: begin
                if (sel_ready_s) begin
                    flag_d[FLG_C] = cout_in;
                    flag_d[FLG_Z] = zero_in;
                    state_d       = ST_UPDATE;
                end else if (wd_expired_s) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FLT_EXEC;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_UPDATE: begin
                pc_d    = br_taken_q ? br_target_q : (pc_q + PC_STEP_V);
                state_d = halt_req ? ST_IDLE : ST_FETCH;
            end
            ST_FAULT: begin
                if (start) begin
                    fault_d      = 1'b0;
                    fault_code_d = FLT_NONE;
                    pc_d         = PC_RST_V;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_fcu_d = (state_d == ST_FETCH);
        cs_dec_d = (state_d == ST_DECODE);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        for (int i = 0; i < N_EU; i++) begin
            cs_eu_d[i] = (state_d == ST_EXEC) && (eu_idx_d == EU_SEL_W'(i));
        end
    end

    // State and output registers; reset drops every cs asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= PC_RST_V;
            ir_q         <= {IR_W{1'b0}};
            flag_q       <= 2'b00;
            eu_idx_q     <= {EU_SEL_W{1'b0}};
            br_taken_q   <= 1'b0;
            br_target_q  <= {ADDR_W{1'b0}};
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            cs_fcu_q     <= 1'b0;
            cs_dec_q     <= 1'b0;
            cs_eu_q      <= {N_EU{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            flag_q       <= flag_d;
            eu_idx_q     <= eu_idx_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            cs_fcu_q     <= cs_fcu_d;
            cs_dec_q     <= cs_dec_d;
            cs_eu_q      <= cs_eu_d;
            busy_q       <= busy_d;
        end
    end

    assign cs_fcu        = cs_fcu_q;
    assign fetch_address = pc_q;
    assign ir            = ir_q;
    assign cs_dec        = cs_dec_q;
    assign cs_eu         = cs_eu_q;
    assign flag          = flag_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;

endmodule
